bcd_conv_arbiter: RTL and testbench
===================================

Name: bcd_conv_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one binary-to-BCD converter (trigger/idle/bcd interface, 16-bit binary in, 4-digit packed BCD out) among N_REQ requesters.
- Per granted request, the block:
  - latches the requester's operand and clamps it to the 4-digit range;
  - fires the converter and waits for completion;
  - returns the BCD result with a one-cycle response pulse to that requester only.
- Sits between display/UART formatting clients and the single converter instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BCD_MAX, 9999, largest representable value; larger inputs are clamped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level; held high until matching rsp_valid bit
- bin_in  in  16*N_REQ  operand of requester i at bits [16*i+15:16*i]; stable while req[i] high
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: result for requester i ready
- rsp_bcd  out  16  packed BCD result, valid with rsp_valid, held until next response
- rsp_ovf  out  1  result was clamped (input > BCD_MAX), valid with rsp_valid
- busy  out  1  high in any state other than S_ARB
- conv_trigger  out  1  start pulse to converter
- conv_in  out  16  operand to converter, registered, stable from trigger to completion
- conv_idle  in  1  converter idle flag; low while converting
- conv_bcd  in  16  converter result, valid when conv_idle returns high

Behaviour:
- Reset values: rsp_valid=0, rsp_bcd=0, rsp_ovf=0, conv_trigger=0, conv_in=0, busy=0, state=S_ARB, round-robin pointer=0, latched owner=0.
- All outputs are registered.
- S_ARB:
  - If any req bit is high, grant the first requester at or after the pointer, scanning upward and wrapping modulo N_REQ.
  - Latch the owner index.
  - Load conv_in = min(bin_in[owner], BCD_MAX); latch ovf = (bin_in[owner] > BCD_MAX).
  - Pointer becomes (owner+1) mod N_REQ.
  - Go to S_START.
  - If no req bit is high, stay in S_ARB.
- S_START: conv_trigger=1 for exactly this one cycle; go to S_WAIT_BUSY.
- S_WAIT_BUSY: wait until conv_idle=0, then go to S_WAIT_DONE.
- S_WAIT_DONE:
  - On conv_idle=1: capture conv_bcd into rsp_bcd and ovf into rsp_ovf; pulse rsp_valid[owner] for one cycle; go to S_ARB.
- Latency from grant to rsp_valid: 3 cycles plus the converter busy time.
- The arbiter adds 3 cycles of overhead per request. No back-to-back overlap: one conversion is in flight at a time.
- Requester rules:
  - req[i] may drop only in the cycle after rsp_valid[i].
  - If req[i] is still high in S_ARB after its response, it is treated as a new request and arbitrated normally. The pointer guarantees other pending requesters are served first.
  - A req deasserted before its response is protocol misuse: the in-flight conversion completes and rsp_valid is still pulsed.
- Simultaneous requests: exactly one grant per S_ARB visit. Worst-case wait for any requester is N_REQ-1 conversions.
- Clamp rule: unsigned compare on the full 16 bits. 9999 passes unclamped; 10000 and above clamp to 9999 (0x9999) with rsp_ovf=1.
- Reset mid-conversion:
  - The arbiter returns to S_ARB immediately. No rsp_valid is issued for the aborted request.
  - The converter is reset by the same reset signal.
- rsp_bcd/rsp_ovf hold their last values between responses.

Test Plan:
- Only req[0] high, bin_in[0]=1234 -> conv_trigger pulses once; rsp_valid=4'b0001 once; rsp_bcd=0x1234; rsp_ovf=0; busy low afterward.
- req=4'b1111 with operands 1,22,333,4444, all held until served -> responses in order 0,1,2,3 with 0x0001, 0x0022, 0x0333, 0x4444; each response exactly one cycle.
- Pointer=3 (after serving 2), then req=4'b1001 -> requester 3 served before 0; then req[3] held high -> 0 served next, then 3 again.
- bin_in[1]=65535 -> rsp_bcd=0x9999, rsp_ovf=1. bin_in[1]=9999 -> 0x9999, rsp_ovf=0. bin_in[1]=10000 -> 0x9999, rsp_ovf=1. bin_in[1]=0 -> 0x0000.
- Reset asserted 10 cycles after conv_trigger -> no rsp_valid; all outputs at reset values next cycle; a following request for 42 -> 0x0042.
- Converter model with 40-cycle busy time and conv_idle low on the cycle after trigger -> rsp_valid occurs 43 cycles after grant; conv_in stable throughout.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one binary-to-BCD converter among N_REQ
// requesters. For each grant it clamps the operand to the 4-digit range,
// fires the converter, waits for it to finish and returns the packed BCD
// result with a one-cycle response pulse to the granted requester.
//
// Handshake: a requester raises req[i] with a stable bin_in slice and holds
// it until rsp_valid[i] pulses. The result (rsp_bcd/rsp_ovf) is valid with
// that pulse and held until the next response. The converter is started by a
// one-cycle conv_trigger and is done when conv_idle returns high after
// having gone low.
module bcd_conv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BCD_MAX = 9999
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  bin_in,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_bcd,
    output logic                 rsp_ovf,
    output logic                 busy,
    output logic                 conv_trigger,
    output logic [15:0]          conv_in,
    input  logic                 conv_idle,
    input  logic [15:0]          conv_bcd,
    output logic [1:0]           dbg_state
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0] MAX16 = 16'(BCD_MAX);

    typedef enum logic [1:0] {
        S_ARB       = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    owner, owner_n;
    logic             ovf, ovf_n;
    logic [15:0]      conv_in_n;
    logic             conv_trigger_n;
    logic             busy_n;
    logic [N_REQ-1:0] rsp_valid_n;
    logic [15:0]      rsp_bcd_n;
    logic             rsp_ovf_n;
    logic             found;
    int               scan;
    int               sel;
    logic [15:0]      operand;

    assign dbg_state = state;

    // Next-state, grant selection and next values of every registered output.
    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        ovf_n       = ovf;
        conv_in_n   = conv_in;
        rsp_valid_n = '0;
        rsp_bcd_n   = rsp_bcd;
        rsp_ovf_n   = rsp_ovf;
        found       = 1'b0;
        scan        = 0;
        sel         = 0;
        operand     = '0;
        case (state)
            S_ARB: begin
                // Scan upward from the pointer, wrapping, first hit wins.
                for (int i = 0; i < N_REQ; i++) begin
                    scan = int'(ptr) + i;
                    if (scan >= N_REQ) scan = scan - N_REQ;
                    if (!found && req[scan]) begin
                        found = 1'b1;
                        sel   = scan;
                    end
                end
                if (found) begin
                    owner_n   = PW'(sel);
                    operand   = bin_in[16*sel +: 16];
                    ovf_n     = (operand > MAX16);
                    conv_in_n = ovf_n ? MAX16 : operand;
                    ptr_n     = (sel == N_REQ - 1) ? '0 : PW'(sel + 1);
                    state_n   = S_START;
                end
            end
            S_START: state_n = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!conv_idle) state_n = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (conv_idle) begin
                    rsp_bcd_n          = conv_bcd;
                    rsp_ovf_n          = ovf;
                    rsp_valid_n[owner] = 1'b1;
                    state_n            = S_ARB;
                end
            end
            default: state_n = S_ARB;
        endcase
        // Trigger is high exactly while the FSM sits in S_START.
        conv_trigger_n = (state_n == S_START);
        busy_n         = (state_n != S_ARB);
    end

    // State register and registered outputs; reset aborts any conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_ARB;
            ptr          <= '0;
            owner        <= '0;
            ovf          <= 1'b0;
            conv_in      <= '0;
            conv_trigger <= 1'b0;
            busy         <= 1'b0;
            rsp_valid    <= '0;
            rsp_bcd      <= '0;
            rsp_ovf      <= 1'b0;
        end else begin
            state        <= state_n;
            ptr          <= ptr_n;
            owner        <= owner_n;
            ovf          <= ovf_n;
            conv_in      <= conv_in_n;
            conv_trigger <= conv_trigger_n;
            busy         <= busy_n;
            rsp_valid    <= rsp_valid_n;
            rsp_bcd      <= rsp_bcd_n;
            rsp_ovf      <= rsp_ovf_n;
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a behavioural converter model
// whose busy time is adjustable per test.
module tb_bcd_conv_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [16*N-1:0] bin_in;
    logic [N-1:0]    rsp_valid;
    logic [15:0]     rsp_bcd;
    logic            rsp_ovf;
    logic            busy;
    logic            conv_trigger;
    logic [15:0]     conv_in;
    logic            conv_idle;
    logic [15:0]     conv_bcd;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int conv_lat = 3;
    int conv_cnt;
    int trig_seen;
    int ci_changes;
    int cyc;
    int pulses;
    logic [15:0] ci_ref;

    bcd_conv_arbiter #(.N_REQ(N), .BCD_MAX(9999)) dut (
        .clk(clk), .reset(reset), .req(req), .bin_in(bin_in),
        .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd), .rsp_ovf(rsp_ovf),
        .busy(busy), .conv_trigger(conv_trigger), .conv_in(conv_in),
        .conv_idle(conv_idle), .conv_bcd(conv_bcd), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input logic [15:0] b);
        int v;
        v = int'(b);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Converter model: idle drops the cycle after trigger, stays low conv_lat cycles.
    always @(posedge clk) begin
        if (reset) begin
            conv_idle <= 1'b1;
            conv_bcd  <= '0;
            conv_cnt  <= 0;
        end else if (conv_trigger) begin
            conv_idle <= 1'b0;
            conv_cnt  <= conv_lat - 1;
        end else if (!conv_idle) begin
            if (conv_cnt == 0) begin
                conv_idle <= 1'b1;
                conv_bcd  <= to_bcd(conv_in);
            end else begin
                conv_cnt <= conv_cnt - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step until a response appears (bounded), tracking trigger pulses and conv_in stability.
    task automatic wait_rsp(input int limit);
        cyc        = 0;
        trig_seen  = 0;
        ci_changes = 0;
        while (rsp_valid == '0 && cyc < limit) begin
            step();
            cyc++;
            if (conv_trigger) begin
                trig_seen++;
                ci_ref = conv_in;
            end else if (trig_seen > 0 && conv_in !== ci_ref) begin
                ci_changes++;
            end
        end
        check("rsp_seen", 32'(rsp_valid != '0), 32'd1);
    endtask

    task automatic set_req(input int i, input logic [15:0] v);
        bin_in[16*i +: 16] = v;
        req[i] = 1'b1;
    endtask

    logic [15:0] t2_bcd [4] = '{16'h0001, 16'h0022, 16'h0333, 16'h4444};
    logic [15:0] t4_in  [4] = '{16'd9999, 16'd10000, 16'd0, 16'd65535};
    logic [15:0] t4_bcd [4] = '{16'h9999, 16'h9999, 16'h0000, 16'h9999};
    logic        t4_ovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset  = 1'b1;
        req    = '0;
        bin_in = '0;
        step();
        step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trigger", 32'(conv_trigger), 32'd0);
        check("rst_conv_in", 32'(conv_in), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        step();

        // Single requester 0 with 1234
        set_req(0, 16'd1234);
        wait_rsp(50);
        check("t1_latency", 32'(cyc), 32'd6);
        check("t1_trig_count", 32'(trig_seen), 32'd1);
        check("t1_rsp_valid", 32'(rsp_valid), 32'b0001);
        check("t1_rsp_bcd", 32'(rsp_bcd), 32'h1234);
        check("t1_rsp_ovf", 32'(rsp_ovf), 32'd0);
        req[0] = 1'b0;
        step();
        check("t1_pulse_once", 32'(rsp_valid), 32'd0);
        check("t1_busy_low", 32'(busy), 32'd0);

        // All four at once, pointer restarted at 0 by reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 16'd1);
        set_req(1, 16'd22);
        set_req(2, 16'd333);
        set_req(3, 16'd4444);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(50);
            check($sformatf("t2_valid_%0d", k), 32'(rsp_valid), 32'(1 << k));
            check($sformatf("t2_bcd_%0d", k), 32'(rsp_bcd), 32'(t2_bcd[k]));
            req[k] = 1'b0;
            step();
            check($sformatf("t2_one_cycle_%0d", k), 32'(rsp_valid), 32'd0);
        end

        // Serve 2 so the pointer moves to 3, then 3 beats 0, then held 3 waits for 0
        set_req(2, 16'd5);
        wait_rsp(50);
        check("t3_valid_2", 32'(rsp_valid), 32'b0100);
        req[2] = 1'b0;
        step();
        set_req(0, 16'd11);
        set_req(3, 16'd33);
        wait_rsp(50);
        check("t3_first_3", 32'(rsp_valid), 32'b1000);
        check("t3_bcd_33", 32'(rsp_bcd), 32'h0033);
        step();
        wait_rsp(50);
        check("t3_then_0", 32'(rsp_valid), 32'b0001);
        check("t3_bcd_11", 32'(rsp_bcd), 32'h0011);
        req[0] = 1'b0;
        step();
        wait_rsp(50);
        check("t3_then_3", 32'(rsp_valid), 32'b1000);
        req[3] = 1'b0;
        step();

        // Clamp boundaries on requester 1
        for (int k = 0; k < 4; k++) begin
            set_req(1, t4_in[k]);
            wait_rsp(50);
            check($sformatf("t4_valid_%0d", k), 32'(rsp_valid), 32'b0010);
            check($sformatf("t4_bcd_%0d", k), 32'(rsp_bcd), 32'(t4_bcd[k]));
            check($sformatf("t4_ovf_%0d", k), 32'(rsp_ovf), 32'(t4_ovf[k]));
            req[1] = 1'b0;
            step();
        end
        check("t4_conv_in_clamped", 32'(conv_in), 32'd9999);

        // Reset ten cycles into a conversion
        conv_lat = 40;
        set_req(2, 16'd500);
        cyc = 0;
        while (!conv_trigger && cyc < 20) begin
            step();
            cyc++;
        end
        check("t5_trigger_seen", 32'(conv_trigger), 32'd1);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (rsp_valid != '0) pulses++;
        end
        check("t5_busy_mid", 32'(busy), 32'd1);
        reset = 1'b1;
        req   = '0;
        step();
        if (rsp_valid != '0) pulses++;
        check("t5_no_rsp", 32'(pulses), 32'd0);
        check("t5_rsp_bcd", 32'(rsp_bcd), 32'd0);
        check("t5_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("t5_conv_in", 32'(conv_in), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_trigger", 32'(conv_trigger), 32'd0);
        check("t5_state", 32'(dbg_state), 32'd0);
        reset    = 1'b0;
        conv_lat = 3;
        step();
        set_req(0, 16'd42);
        wait_rsp(50);
        check("t5_after_valid", 32'(rsp_valid), 32'b0001);
        check("t5_after_bcd", 32'(rsp_bcd), 32'h0042);
        req[0] = 1'b0;
        step();

        // Long converter: 40 busy cycles gives 43 cycles grant-to-response
        conv_lat = 40;
        set_req(3, 16'd1234);
        wait_rsp(100);
        check("t6_latency", 32'(cyc), 32'd43);
        check("t6_trig_count", 32'(trig_seen), 32'd1);
        check("t6_conv_in_stable", 32'(ci_changes), 32'd0);
        check("t6_conv_in", 32'(conv_in), 32'd1234);
        check("t6_valid", 32'(rsp_valid), 32'b1000);
        check("t6_bcd", 32'(rsp_bcd), 32'h1234);
        req[3] = 1'b0;
        step();
        check("t6_busy_low", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
